// File: rtl/alu_pkg.sv
// Op codes (MIPS funct encoding) and flag-bundle layout shared by the
// execute-stage ALU and anything that decodes its status.
package alu_pkg;

  localparam logic [5:0] ALU_SLL  = 6'b000000;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_SRA  = 6'b000011;
  localparam logic [5:0] ALU_SLLV = 6'b000100;
  localparam logic [5:0] ALU_SRLV = 6'b000110;
  localparam logic [5:0] ALU_SRAV = 6'b000111;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_NOR  = 6'b100111;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result plus carry/borrow, signed
// overflow and illegal-op indication.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = $clog2(NB_DATA)
) (
  input  logic [NB_DATA-1:0]  data_a,
  input  logic [NB_DATA-1:0]  data_b,
  input  logic [NB_OP-1:0]    op,
  input  logic [NB_SHAMT-1:0] shamt,
  output logic [NB_DATA-1:0]  result,
  output logic                carry,
  output logic                overflow,
  output logic                illegal
);

  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA:0]    sum;
  logic [NB_DATA:0]    diff;
  logic [NB_SHAMT-1:0] shamt_var;

  // One extra bit captures carry-out on add and borrow on subtract.
  assign sum       = {1'b0, data_a} + {1'b0, data_b};
  assign diff      = {1'b0, data_a} - {1'b0, data_b};
  assign shamt_var = data_b[NB_SHAMT-1:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum[MSB:0];
        carry    = sum[NB_DATA];
        overflow = (data_a[MSB] == data_b[MSB]) && (sum[MSB] != data_a[MSB]);
      end
      ALU_ADDU: begin
        result = sum[MSB:0];
        carry  = sum[NB_DATA];
      end
      ALU_SUB: begin
        result   = diff[MSB:0];
        carry    = diff[NB_DATA];
        overflow = (data_a[MSB] != data_b[MSB]) && (diff[MSB] != data_a[MSB]);
      end
      ALU_SUBU: begin
        result = diff[MSB:0];
        carry  = diff[NB_DATA];
      end
      ALU_AND:  result = data_a & data_b;
      ALU_OR:   result = data_a | data_b;
      ALU_XOR:  result = data_a ^ data_b;
      ALU_NOR:  result = ~(data_a | data_b);
      ALU_SLT:  result = {{(NB_DATA-1){1'b0}}, $signed(data_a) < $signed(data_b)};
      ALU_SLTU: result = {{(NB_DATA-1){1'b0}}, data_a < data_b};
      ALU_SLL:  result = data_a << shamt;
      ALU_SRL:  result = data_a >> shamt;
      ALU_SRA:  result = $signed(data_a) >>> shamt;
      ALU_SLLV: result = data_a << shamt_var;
      ALU_SRLV: result = data_a >> shamt_var;
      ALU_SRAV: result = $signed(data_a) >>> shamt_var;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready flow control: S1 registers the
// operands, S2 registers result and flags; sticky overflow on delivery.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int NB_DATA  = 8,
  parameter  int NB_OP    = 6,
  localparam int NB_SHAMT = $clog2(NB_DATA)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_DATA-1:0]  i_data_a,
  input  logic [NB_DATA-1:0]  i_data_b,
  input  logic [NB_OP-1:0]    i_op,
  input  logic [NB_SHAMT-1:0] i_shamt,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_DATA-1:0]  o_result,
  output logic                o_zero,
  output logic                o_carry,
  output logic                o_overflow,
  output logic                o_illegal,
  output logic                o_ovf_sticky,
  input  logic                i_clr_sticky
);

  logic                s1_valid;
  logic [NB_DATA-1:0]  s1_a;
  logic [NB_DATA-1:0]  s1_b;
  logic [NB_OP-1:0]    s1_op;
  logic [NB_SHAMT-1:0] s1_shamt;

  logic                s2_advance;
  logic [NB_DATA-1:0]  core_result;
  logic                core_carry;
  logic                core_overflow;
  logic                core_illegal;
  alu_flags_t          core_flags;
  alu_flags_t          s2_flags;

  assign s2_advance = !o_valid || i_ready;
  assign o_ready    = !s1_valid || s2_advance;

  alu_core #(
    .NB_DATA  (NB_DATA),
    .NB_OP    (NB_OP),
    .NB_SHAMT (NB_SHAMT)
  ) u_core (
    .data_a   (s1_a),
    .data_b   (s1_b),
    .op       (s1_op),
    .shamt    (s1_shamt),
    .result   (core_result),
    .carry    (core_carry),
    .overflow (core_overflow),
    .illegal  (core_illegal)
  );

  // An illegal op reports only o_illegal; zero is suppressed with the rest.
  assign core_flags = '{
    zero:     (core_result == '0) && !core_illegal,
    carry:    core_carry,
    overflow: core_overflow,
    illegal:  core_illegal
  };

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_reset) begin
      s1_valid <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
    end
  end

  // NOTE: operand registers carry no reset; s1_valid alone decides whether they mean anything.
  always_ff @(posedge i_clk) begin
    if (o_ready && i_valid) begin
      s1_a     <= i_data_a;
      s1_b     <= i_data_b;
      s1_op    <= i_op;
      s1_shamt <= i_shamt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      s2_flags <= '0;
    end else if (s2_advance) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= core_result;
        s2_flags <= core_flags;
      end
    end
  end

  // Set has priority over clear so a delivered overflow is never lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ovf_sticky <= 1'b0;
    end else if (o_valid && i_ready && s2_flags.overflow) begin
      o_ovf_sticky <= 1'b1;
    end else if (i_clr_sticky) begin
      o_ovf_sticky <= 1'b0;
    end
  end

  assign o_zero     = s2_flags.zero;
  assign o_carry    = s2_flags.carry;
  assign o_overflow = s2_flags.overflow;
  assign o_illegal  = s2_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized
// traffic scored against an arithmetic reference model and a result queue.
module tb_alu_pipe;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data_a;
  logic [7:0] i_data_b;
  logic [5:0] i_op;
  logic [2:0] i_shamt;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_result;
  logic       o_zero;
  logic       o_carry;
  logic       o_overflow;
  logic       o_illegal;
  logic       o_ovf_sticky;
  logic       i_clr_sticky;

  alu_pipe #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data_a     (i_data_a),
    .i_data_b     (i_data_b),
    .i_op         (i_op),
    .i_shamt      (i_shamt),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_zero       (o_zero),
    .o_carry      (o_carry),
    .o_overflow   (o_overflow),
    .o_illegal    (o_illegal),
    .o_ovf_sticky (o_ovf_sticky),
    .i_clr_sticky (i_clr_sticky)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       ill;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       in_hs = 1'b0;
  logic       out_hs = 1'b0;
  logic       held = 1'b0;
  logic [11:0] held_val;
  logic       exp_sticky = 1'b0;

  // Reference model written from the operation table with integer arithmetic.
  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op, input logic [2:0] sh);
    exp_t e;
    int ua, ub, sa, sb, r, bs;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    bs = ub % 8;
    r = 0;
    e = '0;
    case (op)
      6'b100000: begin r = ua + ub; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
      6'b100001: begin r = ua + ub; e.c = (r > 255); end
      6'b100010: begin r = ua - ub; e.c = (ua < ub); e.v = (sa - sb > 127) || (sa - sb < -128); end
      6'b100011: begin r = ua - ub; e.c = (ua < ub); end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = ~(ua | ub);
      6'b101010: r = (sa < sb) ? 1 : 0;
      6'b101011: r = (ua < ub) ? 1 : 0;
      6'b000000: r = ua << sh;
      6'b000010: r = ua >> sh;
      6'b000011: r = sa >>> sh;
      6'b000100: r = ua << bs;
      6'b000110: r = ua >> bs;
      6'b000111: r = sa >>> bs;
      default:   e.ill = 1'b1;
    endcase
    e.res = e.ill ? 8'h00 : r[7:0];
    e.z = (e.res == 8'h00) && !e.ill;
    return e;
  endfunction

  // One clock: score handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    logic ovf_hs;
    ovf_hs = 1'b0;
    @(negedge i_clk);
    in_hs  = i_valid && o_ready;
    out_hs = o_valid && i_ready;
    if (held) begin
      checks++;
      if ({o_result, o_zero, o_carry, o_overflow, o_illegal} !== held_val) begin
        errors++;
        $display("FAIL stall_stable got=%h expected=%h", {o_result, o_zero, o_carry, o_overflow, o_illegal}, held_val);
      end
    end
    if (i_reset) begin
      sb_q.delete();
      held = 1'b0;
      exp_sticky = 1'b0;
    end else begin
      if (out_hs) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got=%h expected no result", o_result);
        end else begin
          e = sb_q.pop_front();
          ovf_hs = e.v;
          if ({o_result, o_zero, o_carry, o_overflow, o_illegal} !== {e.res, e.z, e.c, e.v, e.ill}) begin
            errors++;
            $display("FAIL result_flags got r=%h zcvi=%b%b%b%b expected r=%h zcvi=%b%b%b%b",
                     o_result, o_zero, o_carry, o_overflow, o_illegal, e.res, e.z, e.c, e.v, e.ill);
          end
        end
      end
      if (ovf_hs) exp_sticky = 1'b1;
      else if (i_clr_sticky) exp_sticky = 1'b0;
      held = o_valid && !i_ready;
      held_val = {o_result, o_zero, o_carry, o_overflow, o_illegal};
      if (in_hs) sb_q.push_back(ref_model(i_data_a, i_data_b, i_op, i_shamt));
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_ovf_sticky !== exp_sticky) begin
      errors++;
      $display("FAIL sticky got=%b expected=%b", o_ovf_sticky, exp_sticky);
    end
  endtask

  task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, input logic [2:0] sh);
    i_data_a = a;
    i_data_b = b;
    i_op     = op;
    i_shamt  = sh;
  endtask

  // Single transaction with no stall; afterwards its result sits on the outputs.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, input logic [2:0] sh);
    i_ready = 1'b1;
    set_in(a, b, op, sh);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while ((sb_q.size() != 0 || o_valid) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d o_valid=%b expected pending=0 o_valid=0", sb_q.size(), o_valid);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clr_sticky = 1'b0;
    set_in(8'h00, 8'h00, 6'b000000, 3'd0);
    tick();
    tick();
    i_reset = 1'b0;
    checks++;
    if ({o_valid, o_ready, o_ovf_sticky} !== 3'b010) begin
      errors++;
      $display("FAIL reset_handshake got v/rdy/sticky=%b%b%b expected 010", o_valid, o_ready, o_ovf_sticky);
    end
    checks++;
    if ({o_result, o_zero, o_carry, o_overflow, o_illegal} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=000", {o_result, o_zero, o_carry, o_overflow, o_illegal});
    end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    set_in(8'h0A, 8'h05, 6'b100000, 3'd0);
    i_valid = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got o_valid=%b expected 0", o_valid);
    end
    set_in(8'h0C, 8'h03, 6'b100010, 3'd0);
    tick();
    i_valid = 1'b0;
    checks++;
    if ({o_valid, o_result, o_zero, o_carry, o_overflow} !== {1'b1, 8'h0F, 3'b000}) begin
      errors++;
      $display("FAIL add_basic got v=%b r=%h zcv=%b%b%b expected v=1 r=0f zcv=000", o_valid, o_result, o_zero, o_carry, o_overflow);
    end
    tick();
    checks++;
    if ({o_valid, o_result} !== {1'b1, 8'h09}) begin
      errors++;
      $display("FAIL sub_back_to_back got v=%b r=%h expected v=1 r=09", o_valid, o_result);
    end
    drain();
  endtask

  task automatic test_overflow();
    i_ready = 1'b1;
    set_in(8'h64, 8'h64, 6'b100000, 3'd0);
    i_valid = 1'b1;
    tick();
    set_in(8'h64, 8'h64, 6'b100001, 3'd0);
    tick();
    i_valid = 1'b0;
    checks++;
    if ({o_result, o_carry, o_overflow, o_ovf_sticky} !== {8'hC8, 3'b010}) begin
      errors++;
      $display("FAIL add_overflow got r=%h c=%b v=%b sticky=%b expected r=c8 c=0 v=1 sticky=0", o_result, o_carry, o_overflow, o_ovf_sticky);
    end
    tick();
    checks++;
    if ({o_result, o_overflow, o_ovf_sticky} !== {8'hC8, 2'b01}) begin
      errors++;
      $display("FAIL addu_no_overflow got r=%h v=%b sticky=%b expected r=c8 v=0 sticky=1", o_result, o_overflow, o_ovf_sticky);
    end
    tick();
    tick();
    i_clr_sticky = 1'b1;
    tick();
    i_clr_sticky = 1'b0;
    checks++;
    if (o_ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear got=%b expected=0", o_ovf_sticky);
    end
    issue(8'h64, 8'h64, 6'b100000, 3'd0);
    i_clr_sticky = 1'b1;
    tick();
    checks++;
    if (o_ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins got=%b expected=1", o_ovf_sticky);
    end
    tick();
    i_clr_sticky = 1'b0;
    drain();
  endtask

  task automatic test_sub_slt();
    issue(8'h03, 8'h0C, 6'b100011, 3'd0);
    checks++;
    if ({o_result, o_carry, o_overflow} !== {8'hF7, 2'b10}) begin
      errors++;
      $display("FAIL subu_borrow got r=%h c=%b v=%b expected r=f7 c=1 v=0", o_result, o_carry, o_overflow);
    end
    issue(8'hF0, 8'h01, 6'b101010, 3'd0);
    checks++;
    if (o_result !== 8'h01) begin
      errors++;
      $display("FAIL slt got=%h expected=01", o_result);
    end
    issue(8'hF0, 8'h01, 6'b101011, 3'd0);
    checks++;
    if ({o_result, o_zero} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL sltu got r=%h z=%b expected r=00 z=1", o_result, o_zero);
    end
    drain();
  endtask

  task automatic test_shifts();
    logic [7:0] exp_r [4];
    logic [7:0] a_v   [4];
    logic [7:0] b_v   [4];
    logic [5:0] op_v  [4];
    logic [2:0] sh_v  [4];
    exp_r = '{8'hF8, 8'h78, 8'hFF, 8'h80};
    a_v   = '{8'hF0, 8'hF0, 8'hF0, 8'h01};
    b_v   = '{8'h00, 8'h00, 8'h04, 8'h00};
    op_v  = '{6'b000011, 6'b000010, 6'b000111, 6'b000000};
    sh_v  = '{3'd1, 3'd1, 3'd0, 3'd7};
    for (int k = 0; k < 4; k++) begin
      issue(a_v[k], b_v[k], op_v[k], sh_v[k]);
      checks++;
      if (o_result !== exp_r[k]) begin
        errors++;
        $display("FAIL shift_%0d got=%h expected=%h", k, o_result, exp_r[k]);
      end
    end
    drain();
  endtask

  task automatic test_illegal();
    issue(8'h55, 8'hAA, 6'b111111, 3'd2);
    checks++;
    if ({o_valid, o_result, o_zero, o_carry, o_overflow, o_illegal} !== {1'b1, 8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL illegal_op got v=%b r=%h zcvi=%b%b%b%b expected v=1 r=00 zcvi=0001",
               o_valid, o_result, o_zero, o_carry, o_overflow, o_illegal);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int idx;
    int n;
    idx = 0;
    i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_in(8'(16 * (idx + 1)), 8'(idx + 1), 6'b100000, 3'd0);
      i_valid = 1'b1;
      tick();
      if (in_hs) idx++;
    end
    checks++;
    if ({idx[1:0], o_ready, o_valid} !== 4'b1001) begin
      errors++;
      $display("FAIL full_stall got accepted=%0d o_ready=%b o_valid=%b expected accepted=2 o_ready=0 o_valid=1", idx, o_ready, o_valid);
    end
    i_ready = 1'b1;
    n = 0;
    while (idx < 3 && n < 6) begin
      set_in(8'(16 * (idx + 1)), 8'(idx + 1), 6'b100000, 3'd0);
      tick();
      if (in_hs) idx++;
      n++;
    end
    i_valid = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL third_accept got accepted=%0d expected=3", idx);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    issue(8'h64, 8'h64, 6'b100000, 3'd0);
    tick();
    checks++;
    if (o_ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_precondition got=%b expected=1", o_ovf_sticky);
    end
    i_ready = 1'b0;
    set_in(8'h11, 8'h22, 6'b100001, 3'd0);
    i_valid = 1'b1;
    tick();
    set_in(8'h33, 8'h44, 6'b100101, 3'd0);
    tick();
    i_valid = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++;
    if ({o_valid, o_ready, o_ovf_sticky} !== 3'b010) begin
      errors++;
      $display("FAIL midflight_reset got v/rdy/sticky=%b%b%b expected 010", o_valid, o_ready, o_ovf_sticky);
    end
    checks++;
    if ({o_result, o_zero, o_carry, o_overflow, o_illegal} !== 12'h000) begin
      errors++;
      $display("FAIL midflight_outputs got=%h expected=000", {o_result, o_zero, o_carry, o_overflow, o_illegal});
    end
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL discarded_in_flight got o_valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [16];
    ops = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
            6'b000011, 6'b000100, 6'b000110, 6'b000111};
    i_valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!i_valid || in_hs) begin
        i_valid  = ($urandom_range(0, 3) != 0);
        i_data_a = 8'($urandom);
        i_data_b = 8'($urandom);
        i_shamt  = 3'($urandom);
        i_op     = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
      end
      i_ready      = ($urandom_range(0, 3) != 0);
      i_clr_sticky = ($urandom_range(0, 15) == 0);
      tick();
    end
    i_clr_sticky = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sub_slt();
    test_shifts();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the combinational integer ALU in the datapath execute stage. It registers operands and results in two stages with valid/ready flow control. It extends the MIPS-funct operation set with unsigned arithmetic, compare and variable shifts, and adds status flags plus a sticky overflow register. It sits between operand issue and writeback and stalls cleanly under back-pressure.

## Interface
- NB_DATA, 8: operand/result width, ≥4, power of two.
- NB_OP, 6: opcode width (MIPS funct encoding).
- NB_SHAMT, $clog2(NB_DATA): shift-amount width (localparam).

- i_clk  in  1  sole clock.
- i_reset  in  1  synchronous, active-high reset, sampled on rising i_clk.
- i_valid  in  1  input transaction valid.
- o_ready  out  1  block can accept input this cycle.
- i_data_a  in  NB_DATA  operand A (signed).
- i_data_b  in  NB_DATA  operand B (signed).
- i_op  in  NB_OP  operation code.
- i_shamt  in  NB_SHAMT  immediate shift amount.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  NB_DATA  result (signed).
- o_zero / o_carry / o_overflow / o_illegal  out  1 each  flags qualified by o_valid.
- o_ovf_sticky  out  1  set by any delivered overflow.
- i_clr_sticky  in  1  clears o_ovf_sticky.

## Operation
- Ops: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011.
- Immediate shifts: SLL 000000, SRL 000010, SRA 000011 shift A by i_shamt.
- Variable shifts: SLLV 000100, SRLV 000110, SRAV 000111 shift A by B[NB_SHAMT-1:0].
- Arithmetic is computed at NB_DATA+1 bits. o_carry is the carry-out for ADD/ADDU and the borrow (A<B unsigned) for SUB/SUBU. o_carry is 0 for all other ops.
- o_overflow is two's-complement overflow for ADD/SUB only. It is 0 for ADDU/SUBU and all other ops.
- SLT/SLTU return 1 or 0, zero-extended to NB_DATA.
- o_zero is (o_result == 0).
- Any other op code: o_result=0, o_illegal=1, other flags 0. The op still flows through the pipeline normally.
- o_ovf_sticky sets on the cycle a result with o_overflow=1 is accepted (o_valid && i_ready). It clears on i_clr_sticky. Set and clear in the same cycle: set wins.

## Timing
- Stage S1 registers operands, op and shamt. Stage S2 computes and registers result and flags.
- Latency: o_valid rises 2 cycles after an input handshake when there is no stall. Throughput is 1 per cycle.
- A stage advances when its successor is empty or advancing. S2 advances when !o_valid or i_ready.
- o_ready = !s1_valid || S2 advances. o_ready is combinational from i_ready.
- Input handshake: i_valid && o_ready. Output handshake: o_valid && i_ready.
- While o_valid && !i_ready, o_result and all flags stay stable.
- Inputs are ignored when o_ready=0. The upstream must hold them.
- Full condition: both stages valid and i_ready=0, so o_ready=0. Maximum occupancy is 2.
- Reset (any time, including mid-flight): the next cycle has s1_valid=0, o_valid=0, o_ovf_sticky=0, o_result=0, all flags 0 and o_ready=1. In-flight transactions are discarded.

## Structure
- Package alu_pkg holds the op-code localparams (ALU_ADD … ALU_SRAV) and the flag-bundle field order. The execute stage and testbenches share it.
- Sub-module alu_core is purely combinational. It takes A, B, op and shamt and returns result, carry, overflow and illegal. alu_pipe wraps it with the pipeline registers, handshake and sticky logic.

## Test plan
All cases use NB_DATA=8.
- ADD 0x0A+0x05, i_ready=1 -> two cycles later o_result=0x0F, zero/carry/overflow=0. Back-to-back SUB 0x0C−0x03 -> 0x09 on the next cycle.
- ADD 0x64+0x64 -> 0xC8 with overflow=1 and carry=0. o_ovf_sticky goes to 1 and stays there until i_clr_sticky. ADDU with the same operands gives overflow=0.
- SUBU 0x03−0x0C -> 0xF7 with carry=1. SLT 0xF0,0x01 -> 0x01. SLTU with the same operands -> 0x00.
- SRA 0xF0 with shamt=1 -> 0xF8. SRL -> 0x78. SRAV with B=0x04 -> 0xFF. SLL with shamt=7 on 0x01 -> 0x80.
- Hold i_ready=0 and offer 3 inputs -> only 2 accepted and o_ready=0. Release i_ready -> results emerge in order, o_result stable while stalled, the third input is then accepted.
- op=6'b111111 -> o_result=0, o_illegal=1. Assert i_reset with 2 transactions in flight -> next cycle o_valid=0, o_ready=1, sticky=0.
